// File: rtl/idct_out_reorder.sv
// idct_out_reorder
//   Captures one scaled IFFT frame v[n] (N samples, natural order) into a
//   ping-pong buffer and replays it in IDCT output order:
//     x[2m] = v[m], x[2m+1] = v[N-1-m]   for m = 0..N/2-1
//   One bank can be written while the other is read out.
//
// Handshake (both sides): a beat transfers on a clock edge where valid and
//   ready are both high. sop marks the first beat of a frame, eop the last.
//   valid never depends on ready; ready may be low while valid is high.
//
// Ports
//   clk, rst_sync                   clock, synchronous active-high reset
//   sink_valid/ready/sop/eop        input stream control
//   sink_real, sink_imag            input samples (wData bits each)
//   fftpts_in                       frame size N, sampled on the sop beat
//   source_valid/ready/sop/eop      output stream control
//   source_real, source_imag        reordered samples
//   fftpts_out                      N of the frame currently being output
//   frame_err                       one-cycle pulse (cycle after the beat)
//                                   on a framing error or illegal N
//
// Build option
//   IDCT_REORDER_IMAG_EN  defined: imag samples are stored and reordered.
//                         undefined: no imag storage, source_imag stays 0.
module idct_out_reorder #(
  parameter int wData     = 16,
  parameter int MAX_LOG2N = 11
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out,
  output logic             frame_err
);

  localparam int          AW    = MAX_LOG2N;
  localparam int          DEPTH = 2 ** (AW + 1);
  localparam logic [11:0] NMAX  = 12'(2 ** MAX_LOG2N);

  typedef struct packed {
    logic [wData-1:0] re;
    logic [wData-1:0] im;
    logic             sop;
    logic             eop;
    logic [11:0]      n;
    logic             bank;
  } beat_t;

  typedef enum logic {W_IDLE, W_WRITE} wstate_t;
  typedef enum logic {R_IDLE, R_READ}  rstate_t;

  // ---------------------------------------------------------------- storage
  logic [wData-1:0] mem_re [DEPTH];
  logic [wData-1:0] ram_re_q;
  logic [wData-1:0] rd_im;

  // ------------------------------------------------------------- write side
  wstate_t          wstate;
  logic             wbank;
  logic [11:0]      wcnt;
  logic [11:0]      wn;
  logic [1:0]       bank_full;
  logic [1:0][11:0] bank_n;

  logic             wr_fire;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             n_legal;
  logic [11:0]      n_dec;

  // -------------------------------------------------------------- read side
  rstate_t          rstate;
  logic             rbank;
  logic [11:0]      k;
  logic [11:0]      rn;

  logic             rd_vld;
  logic             rd_sop;
  logic             rd_eop;
  logic [11:0]      rd_n;
  logic             rd_bank;

  beat_t [1:0]      q;
  beat_t [1:0]      q_nxt;
  logic [1:0]       fcnt;
  logic [1:0]       fcnt_nxt;
  logic [11:0]      fpts_hold;

  beat_t            rd_item;
  beat_t            head;
  logic             pop;
  logic [2:0]       occ_after;
  logic             can_issue;
  logic             issue;
  logic [11:0]      issue_k;
  logic [11:0]      issue_n;
  logic [11:0]      half_k;
  logic [AW-1:0]    raddr;
  logic             rd_free;

  // A target bank that still holds an unread frame blocks the input.
  assign sink_ready = !bank_full[wbank];
  assign wr_fire    = sink_valid & sink_ready;

  // Legal N: power of two from 32 up to the bank depth; anything else
  // is stored as a full-depth frame.
  assign n_legal = (fftpts_in >= 12'd32) && (fftpts_in <= NMAX) &&
                   ((fftpts_in & (fftpts_in - 12'd1)) == 12'd0);
  assign n_dec   = n_legal ? fftpts_in : NMAX;

  // Beats outside a frame are dropped; a sop beat always lands at address 0.
  assign wr_en   = wr_fire && (sink_sop || (wstate == W_WRITE));
  assign wr_addr = sink_sop ? '0 : wcnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) mem_re[{wbank, wr_addr}] <= sink_real;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wstate    <= W_IDLE;
      wbank     <= 1'b0;
      wcnt      <= '0;
      wn        <= '0;
      bank_full <= '0;
      bank_n    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // The bank being drained is never the write target, so a free and a
      // frame completion in the same cycle touch different bits.
      if (rd_free) bank_full[head.bank] <= 1'b0;
      if (wr_fire) begin
        if (sink_sop) begin
          wn   <= n_dec;
          wcnt <= 12'd1;
          if (sink_eop) begin
            // A one-beat frame is always short.
            wstate    <= W_IDLE;
            frame_err <= 1'b1;
          end else begin
            // sop inside a frame restarts the same bank from address 0.
            wstate    <= W_WRITE;
            frame_err <= !n_legal || (wstate == W_WRITE);
          end
        end else if (wstate == W_WRITE) begin
          if (wcnt == wn - 12'd1) begin
            bank_full[wbank] <= 1'b1;
            bank_n[wbank]    <= wn;
            wbank            <= ~wbank;
            wstate           <= W_IDLE;
            frame_err        <= !sink_eop;
          end else if (sink_eop) begin
            wstate    <= W_IDLE;
            frame_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 12'd1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------- imag storage
`ifdef IDCT_REORDER_IMAG_EN
  logic [wData-1:0] mem_im [DEPTH];
  logic [wData-1:0] ram_im_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_im[{wbank, wr_addr}] <= sink_imag;
  end

  always_ff @(posedge clk) begin
    if (issue) ram_im_q <= mem_im[{rbank, raddr}];
  end

  assign rd_im = ram_im_q;
`else
  logic unused_imag;
  assign unused_imag = ^sink_imag;
  assign rd_im       = '0;
`endif

  // -------------------------------------------------------------- read side
  // Output view is an ordered queue: skid entries (oldest) then the RAM
  // output stage. The RAM stage item is always consumed at the next edge,
  // either popped directly or pushed into the skid buffer.
  always_comb begin
    rd_item = '0;
    if (rd_vld) begin
      rd_item.re   = ram_re_q;
      rd_item.im   = rd_im;
      rd_item.sop  = rd_sop;
      rd_item.eop  = rd_eop;
      rd_item.n    = rd_n;
      rd_item.bank = rd_bank;
    end
  end

  assign head         = (fcnt != 2'd0) ? q[0] : rd_item;
  assign source_valid = (fcnt != 2'd0) || rd_vld;
  assign source_real  = head.re;
  assign source_imag  = head.im;
  assign source_sop   = head.sop;
  assign source_eop   = head.eop;
  assign fftpts_out   = source_valid ? head.n : fpts_hold;

  assign pop     = source_valid && source_ready;
  assign rd_free = pop && head.eop;

  // Issue only if, after this cycle's pop, at most one item remains queued:
  // then the item returning from the RAM next cycle always has a slot.
  assign occ_after = {1'b0, fcnt} + {2'b0, rd_vld} - {2'b0, pop};
  assign can_issue = (occ_after <= 3'd1);
  assign issue     = can_issue && ((rstate == R_READ) || bank_full[rbank]);
  assign issue_k   = (rstate == R_READ) ? k  : 12'd0;
  assign issue_n   = (rstate == R_READ) ? rn : bank_n[rbank];

  // Even k reads from the front half, odd k from the back half.
  assign half_k = {1'b0, issue_k[11:1]};
  assign raddr  = issue_k[0] ? AW'(issue_n - 12'd1 - half_k) : AW'(half_k);

  always_ff @(posedge clk) begin
    if (issue) ram_re_q <= mem_re[{rbank, raddr}];
  end

  always_comb begin
    q_nxt    = q;
    fcnt_nxt = fcnt;
    if (pop && (fcnt != 2'd0)) begin
      q_nxt[0] = q[1];
      fcnt_nxt = fcnt - 2'd1;
    end
    if (rd_vld && !(pop && (fcnt == 2'd0))) begin
      q_nxt[fcnt_nxt[0]] = rd_item;
      fcnt_nxt           = fcnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      rstate    <= R_IDLE;
      rbank     <= 1'b0;
      k         <= '0;
      rn        <= '0;
      rd_vld    <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      rd_n      <= '0;
      rd_bank   <= 1'b0;
      q         <= '0;
      fcnt      <= '0;
      fpts_hold <= '0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_sop  <= (issue_k == 12'd0);
        rd_eop  <= (issue_k == issue_n - 12'd1);
        rd_n    <= issue_n;
        rd_bank <= rbank;
      end
      q    <= q_nxt;
      fcnt <= fcnt_nxt;
      if (source_valid) fpts_hold <= head.n;

      case (rstate)
        R_IDLE: begin
          if (issue) begin
            rn     <= bank_n[rbank];
            k      <= 12'd1;
            rstate <= R_READ;
          end
        end
        R_READ: begin
          if (issue) begin
            // Move on to the other bank as soon as the last index is issued;
            // this bank is freed later when its eop leaves the output.
            if (k == rn - 12'd1) begin
              rstate <= R_IDLE;
              rbank  <= ~rbank;
              k      <= '0;
            end else begin
              k <= k + 12'd1;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_out_reorder.sv
// Directed testbench for idct_out_reorder.
module tb_idct_out_reorder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_sync;
  logic          sink_valid;
  logic          sink_ready;
  logic          sink_sop;
  logic          sink_eop;
  logic [W-1:0]  sink_real;
  logic [W-1:0]  sink_imag;
  logic [11:0]   fftpts_in;
  logic          source_valid;
  logic          source_ready;
  logic          source_sop;
  logic          source_eop;
  logic [W-1:0]  source_real;
  logic [W-1:0]  source_imag;
  logic [11:0]   fftpts_out;
  logic          frame_err;

  idct_out_reorder #(.wData(W), .MAX_LOG2N(11)) dut (
    .clk          (clk),
    .rst_sync     (rst_sync),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out),
    .frame_err    (frame_err)
  );

  // ------------------------------------------------------ clock and reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ scoreboard state
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_im_q[$];
  logic         exp_sop_q[$];
  logic         exp_eop_q[$];
  logic [11:0]  exp_n_q[$];

  logic [W-1:0] got_re[$];
  logic [W-1:0] got_im[$];
  logic         got_sop[$];
  logic         got_eop[$];
  logic [11:0]  got_n[$];
  int           got_cyc[$];

  int fe_cnt       = 0;
  int stalls       = 0;
  int drv_timeouts = 0;
  int acc_cyc      = 0;
  int last_eop_cyc = 0;
  int rise_q[$];
  logic prev_sr    = 1'b1;
  int rdy_mode     = 0;

  // ------------------------------------------------------ output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (source_valid && source_ready) begin
        got_re.push_back(source_real);
        got_im.push_back(source_imag);
        got_sop.push_back(source_sop);
        got_eop.push_back(source_eop);
        got_n.push_back(fftpts_out);
        got_cyc.push_back(cyc);
        if (source_eop) last_eop_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (sink_ready && !prev_sr) rise_q.push_back(cyc - last_eop_cyc);
      prev_sr = sink_ready;
    end
  end

  // source_ready: always 1, or the repeating pattern 1,0,0,1
  initial begin
    int ph;
    ph = 0;
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) begin
        source_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        source_ready = 1'b1;
      end
    end
  end

  // ------------------------------------------------------ helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Expected reordered frame for input samples v[i] = seed + i.
  task automatic push_exp(input int len, input int seed, input logic [11:0] nval);
    int idx;
    logic [W-1:0] v;
    for (int kk = 0; kk < len; kk++) begin
      idx = (kk % 2 == 0) ? (kk / 2) : (len - 1 - kk / 2);
      v = W'(seed + idx);
      exp_q.push_back(v);
`ifdef IDCT_REORDER_IMAG_EN
      exp_im_q.push_back(~v);
`else
      exp_im_q.push_back('0);
`endif
      exp_sop_q.push_back(kk == 0);
      exp_eop_q.push_back(kk == len - 1);
      exp_n_q.push_back(nval);
    end
  endtask

  task automatic send_beat(input logic sop, input logic eop, input logic [11:0] fpts,
                           input logic [W-1:0] re, input logic [W-1:0] im);
    int t;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    fftpts_in  = fpts;
    sink_real  = re;
    sink_imag  = im;
    t = 0;
    @(negedge clk);
    while (!sink_ready && t < 5000) begin
      stalls++;
      t++;
      @(negedge clk);
    end
    if (!sink_ready) drv_timeouts++;
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input logic [11:0] fpts, input int eop_idx, input int seed);
    logic [W-1:0] v;
    for (int i = 0; i < len; i++) begin
      v = W'(seed + i);
      send_beat(i == 0, i == eop_idx, (i == 0) ? fpts : 12'd0, v, ~v);
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    fftpts_in  = 12'd0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int t;
    t = 0;
    while (got_re.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_all();
    exp_q.delete(); exp_im_q.delete(); exp_sop_q.delete(); exp_eop_q.delete(); exp_n_q.delete();
    got_re.delete(); got_im.delete(); got_sop.delete(); got_eop.delete(); got_n.delete(); got_cyc.delete();
  endtask

  task automatic compare_out(input string tag);
    int n, bre, bim, bsop, beop, bn;
    bre = 0; bim = 0; bsop = 0; beop = 0; bn = 0;
    check({tag, "_len"}, got_re.size(), exp_q.size());
    n = (got_re.size() < exp_q.size()) ? got_re.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_re[i]  !== exp_q[i])     bre++;
      if (got_im[i]  !== exp_im_q[i])  bim++;
      if (got_sop[i] !== exp_sop_q[i]) bsop++;
      if (got_eop[i] !== exp_eop_q[i]) beop++;
      if (got_n[i]   !== exp_n_q[i])   bn++;
    end
    check({tag, "_real_errs"}, bre, 0);
    check({tag, "_imag_errs"}, bim, 0);
    check({tag, "_sop_errs"},  bsop, 0);
    check({tag, "_eop_errs"},  beop, 0);
    check({tag, "_fftpts_errs"}, bn, 0);
    clear_all();
  endtask

  // ------------------------------------------------------ directed sequence
  initial begin
    int lat, bad, n, eops;
    rst_sync   = 1'b1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_real  = '0;
    sink_imag  = '0;
    fftpts_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_sync = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_sink_ready",   sink_ready, 1);
    check("rst_source_valid", source_valid, 0);
    check("rst_source_real",  source_real, 0);
    check("rst_source_imag",  source_imag, 0);
    check("rst_source_sop",   source_sop, 0);
    check("rst_source_eop",   source_eop, 0);
    check("rst_fftpts_out",   fftpts_out, 0);
    check("rst_frame_err",    frame_err, 0);
    sync();

    // T1: N=32, samples 0..31 -> 0,31,1,30,...,15,16
    fe_cnt = 0;
    push_exp(32, 0, 12'd32);
    send_frame(32, 12'd32, 31, 0);
    lat = acc_cyc;
    wait_got(32, 200);
    lat = (got_cyc.size() > 0) ? (got_cyc[0] - lat) : -1;
    check("t1_latency", lat, 2);
    compare_out("t1");
    check("t1_frame_err", fe_cnt, 0);
    sync();

    // T2: back-to-back N=64 then N=2048
    stalls = 0;
    push_exp(64, 100, 12'd64);
    push_exp(2048, 16'h1000, 12'd2048);
    send_frame(64, 12'd64, 63, 100);
    send_frame(2048, 12'd2048, 2047, 16'h1000);
    wait_got(2112, 3000);
    check("t2_sink_stalls", stalls, 0);
    compare_out("t2");
    sync();

    // T3: N=256 x3 with source_ready 1,0,0,1
    rdy_mode = 1;
    stalls = 0;
    rise_q.delete();
    push_exp(256, 16'h2000, 12'd256);
    push_exp(256, 16'h3000, 12'd256);
    push_exp(256, 16'h4000, 12'd256);
    send_frame(256, 12'd256, 255, 16'h2000);
    send_frame(256, 12'd256, 255, 16'h3000);
    send_frame(256, 12'd256, 255, 16'h4000);
    wait_got(768, 4000);
    rdy_mode = 0;
    check("t3_backpressure_seen", (stalls > 0), 1);
    check("t3_ready_rise_seen", (rise_q.size() > 0), 1);
    bad = 0;
    foreach (rise_q[i]) if (rise_q[i] != 1) bad++;
    check("t3_ready_rise_delay_errs", bad, 0);
    compare_out("t3");
    sync();

    // T4: N=128 with eop on the 100th beat, then a good N=128 frame
    fe_cnt = 0;
    send_frame(100, 12'd128, 99, 16'h5000);
    repeat (20) @(negedge clk);
    check("t4_err_pulses", fe_cnt, 1);
    check("t4_no_output", got_re.size(), 0);
    sync();
    push_exp(128, 16'h6000, 12'd128);
    send_frame(128, 12'd128, 127, 16'h6000);
    wait_got(128, 500);
    compare_out("t4");
    check("t4_err_after_good", fe_cnt, 1);
    sync();

    // T5: illegal N=100 handled as 2048, reset mid-output, then clean frame
    fe_cnt = 0;
    push_exp(2048, 16'h7000, 12'd2048);
    send_frame(2048, 12'd100, 2047, 16'h7000);
    n = 0;
    while (got_re.size() < 40 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_err_pulses", fe_cnt, 1);
    sync();
    rst_sync = 1'b1;
    @(posedge clk);
    #1;
    rst_sync = 1'b0;
    check("t5_rst_source_valid", source_valid, 0);
    check("t5_rst_source_real",  source_real, 0);
    check("t5_rst_source_sop",   source_sop, 0);
    check("t5_rst_source_eop",   source_eop, 0);
    check("t5_rst_fftpts_out",   fftpts_out, 0);
    check("t5_rst_frame_err",    frame_err, 0);
    check("t5_rst_sink_ready",   sink_ready, 1);
    check("t5_partial_started", (got_re.size() >= 40), 1);
    check("t5_partial_short",   (got_re.size() < 2048), 1);
    bad = 0;
    eops = 0;
    for (int i = 0; i < got_re.size() && i < exp_q.size(); i++) begin
      if (got_re[i] !== exp_q[i] || got_n[i] !== exp_n_q[i]) bad++;
      if (got_eop[i]) eops++;
    end
    check("t5_prefix_errs", bad, 0);
    check("t5_aborted_eops", eops, 0);
    clear_all();
    repeat (10) @(negedge clk);
    check("t5_quiet_after_reset", got_re.size(), 0);
    sync();
    push_exp(32, 16'h8000, 12'd32);
    send_frame(32, 12'd32, 31, 16'h8000);
    wait_got(32, 200);
    compare_out("t5_clean");

    check("drv_timeouts", drv_timeouts, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idct_out_reorder.md
Name: idct_out_reorder

Overview:
- Sits directly downstream of the post-IFFT scaling stage in the IDCT chain.
- Captures one scaled IFFT frame v[n] of N samples and re-emits it in IDCT output order: x[2m]=v[m], x[2m+1]=v[N-1-m], for m=0..N/2-1.
- Uses a ping-pong frame buffer, so one frame can be written while the previous frame is read out.
- Both sides use the same valid/ready/sop/eop streaming interface as the rest of the chain.

Parameters:
- wData, 16, sample width for real and imag; matches the scaling stage output.
- MAX_LOG2N, 11, log2 of the largest frame size (2048); sets bank depth to 2^MAX_LOG2N.

Ports:
- clk  in  1  clock.
- rst_sync  in  1  synchronous reset, active high.
- sink_valid  in  1  input sample valid.
- sink_ready  out  1  block can accept an input sample.
- sink_sop  in  1  first sample of the input frame.
- sink_eop  in  1  last sample of the input frame.
- sink_real  in  wData  input real sample.
- sink_imag  in  wData  input imag sample.
- fftpts_in  in  12  frame size N; sampled on the sop beat.
- source_valid  out  1  output sample valid.
- source_ready  in  1  downstream accepts the output sample.
- source_sop  out  1  first reordered sample of the frame.
- source_eop  out  1  last reordered sample of the frame.
- source_real  out  wData  reordered real sample.
- source_imag  out  wData  reordered imag sample (see Optional Feature).
- fftpts_out  out  12  N of the frame currently being output.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_sync=1 at a clk edge): all outputs 0 except sink_ready; both banks marked empty; write and read counters cleared; sink_ready=1 from the first cycle after reset. Reset mid-frame discards all buffered and partial data; no source_eop is emitted for the aborted frame.
- Frame size:
  - N is latched at the sop beat. Legal values are 32, 64, 128, 256, 512, 1024, 2048.
  - Any other value is treated as 2048, and frame_err pulses on that sop beat.
  - The latched N travels with its bank and drives fftpts_out while that bank is being read.
- Handshake: an input beat transfers on sink_valid & sink_ready; an output beat transfers on source_valid & source_ready.
- Write side:
  - States IDLE and WRITE.
  - IDLE: beats without sop are dropped. A sop beat writes address 0 and moves to WRITE.
  - WRITE: each beat writes natural-order address wcnt, then wcnt increments.
  - When wcnt reaches N-1, that bank is marked full, the write bank toggles, and the state returns to IDLE.
  - sink_ready=0 whenever the target write bank is still full, i.e. both banks are full.
- Framing errors (each pulses frame_err for one cycle):
  - eop before wcnt=N-1: the frame is discarded, the bank stays empty, state goes to IDLE.
  - Missing eop on wcnt=N-1: the frame is still accepted.
  - sop while in WRITE: the partial frame is discarded and a new frame starts at address 0 in the same bank.
- Read side:
  - States RIDLE and READ. A full bank starts READ, which issues read index k=0..N-1.
  - Read address is k>>1 for even k and N-1-(k>>1) for odd k.
  - The RAM is synchronous with 1-cycle read latency. A 2-entry output skid buffer absorbs backpressure, so source_valid never drops mid-frame while downstream is ready and no beat is lost or duplicated.
  - source_sop is asserted on k=0 and source_eop on k=N-1. The bank is freed on the beat that transfers source_eop.
- Throughput and latency:
  - Sustained 1 sample/clk when source_ready=1.
  - First output beat is 2 cycles after the input beat that completes the frame.
  - The frame-completing write and the bank-freeing read may occur in the same cycle. The freed bank becomes writable next cycle; sink_ready rises in that cycle.

Optional Feature:
- Macro: IDCT_REORDER_IMAG_EN.
- Defined: the imag RAM is instantiated and source_imag carries the reordered imag samples, using the same addressing as real.
- Undefined: no imag storage; sink_imag is ignored and source_imag is held at 0.

Test Plan:
- N=32, sink_real=n for n=0..31, continuous valid, source_ready=1 -> output 0,31,1,30,...,15,16; sop on 0, eop on 16; fftpts_out=32; first output 2 cycles after the input eop.
- Back-to-back frames N=64 then N=2048, no gaps, source_ready=1 -> both frames correctly reordered; sink_ready stays 1 throughout; fftpts_out switches from 64 to 2048 at the second frame's sop.
- N=256 with source_ready toggling 1,0,0,1 repeating -> no lost or duplicated samples; sink_ready drops while both banks are full and recovers one cycle after the bank frees.
- N=128 with eop on the 100th beat -> one frame_err pulse, no output frame; the following valid N=128 frame is reordered correctly.
- fftpts_in=100 at sop -> frame_err pulses and the frame is handled as N=2048; rst_sync asserted mid-output -> all outputs 0 next cycle, and the next frame starts clean.
